// File: rtl/ntlm_candidate_gen.sv
// Brute-force candidate generator feeding the NTLM hash/compare stage.
// Enumerates all strings over a contiguous charset, min_len..max_len, in order.
module ntlm_candidate_gen #(
    parameter logic [7:0] CHAR_BASE  = 8'h61,
    parameter int         CHAR_COUNT = 26,
    parameter int         MAX_CHARS  = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [3:0]   min_len,
    input  logic [3:0]   max_len,
    input  logic         cand_ready,
    output logic         cand_valid,
    output logic [0:127] instr,
    output logic [0:3]   length,
    output logic         done,
    output logic         cfg_err,
    output logic [63:0]  count
);

    localparam logic [7:0] LAST_CHAR = 8'(int'(CHAR_BASE) + CHAR_COUNT - 1);
    localparam logic [3:0] MAX_LEN   = 4'(MAX_CHARS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    logic [3:0]   max_q;
    logic [0:127] nxt_instr;
    logic         carry;
    logic         xfer;
    logic         cfg_ok;

    // First n bytes set to the base symbol, the rest zero.
    function automatic logic [0:127] fill(input logic [3:0] n);
        logic [0:127] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n)) v[8*i +: 8] = CHAR_BASE;
        end
        return v;
    endfunction

    assign xfer   = cand_valid && cand_ready;
    assign cfg_ok = (min_len != 4'd0) && (min_len <= max_len) &&
                    (max_len <= MAX_LEN);

    // Odometer step: rightmost char is least significant, carry moves left.
    always_comb begin
        nxt_instr = instr;
        carry     = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (carry && (i < int'(length))) begin
                if (instr[8*i +: 8] == LAST_CHAR) begin
                    nxt_instr[8*i +: 8] = CHAR_BASE;
                end else begin
                    nxt_instr[8*i +: 8] = instr[8*i +: 8] + 8'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Control FSM with registered candidate, status and counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            max_q      <= 4'd0;
            cand_valid <= 1'b0;
            instr      <= '0;
            length     <= 4'd0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            count      <= 64'd0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            max_q      <= max_len;
                            count      <= 64'd0;
                            done       <= 1'b0;
                            cand_valid <= 1'b1;
                            length     <= min_len;
                            instr      <= fill(min_len);
                            state      <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer && (count != '1)) count <= count + 64'd1;
                    if (abort) begin
                        cand_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (xfer) begin
                        if (!carry) begin
                            instr <= nxt_instr;
                        end else if (length == max_q) begin
                            cand_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            length <= length + 4'd1;
                            instr  <= fill(length + 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
